// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-sliced ALU: op encoding, FSM states, slice geometry.
// Pure declarations; no timing of its own.
// Imported by nibble_alu4 and alu16_seq.
package alu_pkg;

  localparam int NIB     = 4;
  localparam int NUM_NIB = 4;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ADD and SUB share the 11x encoding; everything else is bitwise.
  function automatic logic is_arith(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/nibble_alu4.sv
// 4-bit ALU slice: bitwise ops or add/subtract with carry in/out and carry into bit 3.
// Purely combinational, zero latency.
// No flow control; the caller sequences it.
module nibble_alu4
  import alu_pkg::*;
(
  input  logic [NIB-1:0] a4,
  input  logic [NIB-1:0] b4,
  input  logic           cin,
  input  logic [2:0]     op,
  output logic [NIB-1:0] r4,
  output logic           cout,
  output logic           c3,
  output logic           zero4
);

  logic [NIB-1:0] b_eff;
  logic [NIB:0]   sum;
  logic [NIB-1:0] low_sum;

  // Bitwise result or ripple sum; SUB inverts b and relies on cin for the +1.
  always_comb begin
    b_eff   = op[0] ? ~b4 : b4;
    sum     = {1'b0, a4} + {1'b0, b_eff} + {{NIB{1'b0}}, cin};
    low_sum = {1'b0, a4[NIB-2:0]} + {1'b0, b_eff[NIB-2:0]} + {{(NIB-1){1'b0}}, cin};
    r4      = '0;
    cout    = 1'b0;
    c3      = 1'b0;
    case (op)
      OP_NOTA: r4 = ~a4;
      OP_NOTB: r4 = ~b4;
      OP_AND:  r4 = a4 & b4;
      OP_OR:   r4 = a4 | b4;
      OP_XOR:  r4 = a4 ^ b4;
      OP_XNOR: r4 = ~(a4 ^ b4);
      default: begin
        r4   = sum[NIB-1:0];
        cout = sum[NIB];
        c3   = low_sum[NIB-1];
      end
    endcase
    zero4 = (r4 == '0);
  end

endmodule

// File: rtl/alu16_seq.sv
// 16-bit ALU sequencer: time-multiplexes one 4-bit slice over four nibbles, LSB first.
// Latency: done pulses 5 cycles after the start cycle; busy during the 4 nibble cycles.
// No backpressure; start is only honoured in IDLE or DONE and is dropped while busy.
module alu16_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        v
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_NIB - 1);

  state_t      state;
  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [11:0] acc;
  logic [1:0]  idx;
  logic        carry;
  logic        zacc;

  logic [NIB-1:0] a4;
  logic [NIB-1:0] b4;
  logic           cin;
  logic [NIB-1:0] r4;
  logic           cout;
  logic           c3;
  logic           zero4;

  // Nibble select and carry chain: nibble 0 takes op[0] as carry-in (the +1 of SUB).
  always_comb begin
    a4  = a_q[{idx, 2'b00} +: NIB];
    b4  = b_q[{idx, 2'b00} +: NIB];
    cin = (idx == 2'd0) ? op_q[0] : carry;
  end

  nibble_alu4 u_slice (
    .a4    (a4),
    .b4    (b4),
    .cin   (cin),
    .op    (op_q),
    .r4    (r4),
    .cout  (cout),
    .c3    (c3),
    .zero4 (zero4)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Sequencer: capture on start, one nibble per RUN cycle, commit word and flags together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b1;
      result <= '0;
      c      <= 1'b0;
      n      <= 1'b0;
      z      <= 1'b0;
      v      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            carry <= 1'b0;
            zacc  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          case (idx)
            2'd0:    acc[3:0]  <= r4;
            2'd1:    acc[7:4]  <= r4;
            2'd2:    acc[11:8] <= r4;
            default: ;
          endcase
          carry <= cout;
          zacc  <= zacc & zero4;
          idx   <= idx + 2'd1;
          if (idx == LAST_IDX) begin
            // Top nibble comes straight from the slice so the word commits in one edge.
            state  <= ST_DONE;
            result <= {r4, acc};
            n      <= r4[NIB-1];
            z      <= zacc & zero4;
            c      <= is_arith(op_q) & cout;
            v      <= is_arith(op_q) & (c3 ^ cout);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq with a FIFO scoreboard and an independent done monitor.
module tb_alu16_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c, n, z, v;

  alu16_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c      (c),
    .n      (n),
    .z      (z),
    .v      (v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] r;
    logic        c, n, z, v;
    int          sc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 with result %0h, expected no done (cycle %0d)", result, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result",  result, mon_e.r);
        chk("flag_c",  c, mon_e.c);
        chk("flag_n",  n, mon_e.n);
        chk("flag_z",  z, mon_e.z);
        chk("flag_v",  v, mon_e.v);
        chk("latency", cyc - mon_e.sc, 5);
        chk("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic push(input logic [15:0] r, input logic fc, input logic fn, input logic fz, input logic fv);
    exp_t e;
    e.r = r; e.c = fc; e.n = fn; e.z = fz; e.v = fv; e.sc = cyc;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // One op: operands are scrambled right after acceptance to prove they were captured.
  task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] r, input logic fc, input logic fn,
                       input logic fz, input logic fv);
    drive(o, x, y);
    push(r, fc, fn, fz, fv);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    op = 3'($urandom);
    wait_drain();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},   busy,   1'b0);
    chk({tag, "_done"},   done,   1'b0);
    chk({tag, "_result"}, result, 16'h0000);
    chk({tag, "_flags"},  {c, n, z, v}, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;

    //       op       a         b         result    c     n     z     v
    issue(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(OP_SUB,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(OP_NOTA, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(OP_NOTB, 16'h1234, 16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(OP_OR,   16'h8000, 16'h0001, 16'h8001, 0, 1, 0, 0);

    // XOR, a stray start during RUN, then start held high into DONE for back-to-back.
    drive(OP_XOR, 16'hA5A5, 16'hFFFF);          // cycle s
    push(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;               // s+1
    chk("busy_run", busy, 1'b1);
    @(negedge clk);                             // s+2: ignored
    start = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
    @(negedge clk); start = 1'b0;               // s+3
    drive(OP_AND, 16'hF0F0, 16'h0FF0);          // s+4: held high through RUN
    @(negedge clk);                             // s+5: DONE, accepted here
    push(16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;               // s+6
    wait_drain();

    issue(OP_XNOR, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Abort at idx=2 with start asserted alongside reset.
    drive(OP_ADD, 16'h1111, 16'h2222);          // s
    @(negedge clk); start = 1'b0;               // s+1 idx=0
    @(negedge clk);                             // s+2 idx=1
    @(negedge clk);                             // s+3 idx=2
    reset = 1'b1; start = 1'b1;
    @(negedge clk);                             // s+4
    chk_reset("abort");
    reset = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_after_abort", busy, 1'b0);

    issue(OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
